retire_unit: RTL

Retire stage directly downstream of the 256-entry reorder buffer. Consumes the ROB's registered commit stream one micro-op per cycle and returns superseded physical registers to the free list through a small buffered queue. Pulses store-commit notices to the store buffer. On a committed mispredicted branch, runs a flush/redirect sequence toward the front end and drives `commit_ready_o` back to the ROB.

---
 rtl/retire_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/retire_unit.sv
// retire_unit: retire stage behind the reorder buffer.
// Accepts one commit per cycle in RUN, queues freed physical registers,
// pulses store-commit notices, and runs a flush/redirect sequence on a
// committed mispredicted branch.
// Optional feature macro: RETIRE_PERF_EN enables the retired/flush counters.
module retire_unit #(
  parameter int FREE_Q_DEPTH = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid_i,
  input  logic [7:0]  commit_idx_i,
  input  logic [6:0]  commit_rd_phys_i,
  input  logic [6:0]  commit_old_phys_i,
  input  logic        commit_is_store_i,
  input  logic        commit_branch_misp_i,
  input  logic [63:0] commit_branch_target_i,
  output logic        commit_ready_o,
  output logic        free_valid_o,
  output logic [6:0]  free_phys_o,
  input  logic        free_ready_i,
  output logic        st_commit_valid_o,
  output logic [7:0]  st_commit_idx_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic [63:0] retired_count_o,
  output logic [31:0] flush_count_o
);

  localparam int PW  = $clog2(FREE_Q_DEPTH);
  localparam int CW  = PW + 1;
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {RUN, FLUSH, REDIRECT} state_t;

  state_t          state;
  state_t          state_next;
  logic [FCW-1:0]  flush_cnt;
  logic [63:0]     target;

  logic            accept;
  logic            misp_accept;
  logic            enq;
  logic            deq;

  logic [6:0]      mem [FREE_Q_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_ptr_next;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [6:0]      head_next;

  // The destination register is informational only; folded here so it is visibly consumed.
  logic            unused_rd_phys;
  assign unused_rd_phys = ^commit_rd_phys_i;

  // Wrong-path commits arriving during FLUSH/REDIRECT are simply dropped.
  assign accept      = commit_valid_i && (state == RUN);
  assign misp_accept = accept && commit_branch_misp_i;
  assign enq         = accept && (commit_old_phys_i != 7'd0);
  assign deq         = free_valid_o && free_ready_i;

  // Queue bookkeeping and show-ahead head selection (bypass when the new entry becomes head).
  always_comb begin
    rd_ptr_next = rd_ptr + PW'(deq);
    count_next  = count + CW'(enq) - CW'(deq);
    if (enq && (rd_ptr_next == wr_ptr))
      head_next = commit_old_phys_i;
    else
      head_next = mem[rd_ptr_next];
  end

  // Queue storage: plain RAM array, no reset.
  always_ff @(posedge clk) begin
    if (enq)
      mem[wr_ptr] <= commit_old_phys_i;
  end

  // Queue pointers, count and registered head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      free_valid_o <= 1'b0;
      free_phys_o  <= 7'd0;
    end else begin
      if (enq)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr       <= rd_ptr_next;
      count        <= count_next;
      free_valid_o <= (count_next != '0);
      if (count_next != '0)
        free_phys_o <= head_next;
    end
  end

  // Store-commit notice, one cycle after the accepted store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_commit_valid_o <= 1'b0;
      st_commit_idx_o   <= 8'd0;
    end else begin
      st_commit_valid_o <= accept && commit_is_store_i;
      if (accept && commit_is_store_i)
        st_commit_idx_o <= commit_idx_i;
    end
  end

  // FSM state register plus flush down-counter and captured redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
      target    <= 64'd0;
    end else begin
      state <= state_next;
      if (misp_accept) begin
        flush_cnt <= FCW'(FLUSH_CYCLES);
        target    <= commit_branch_target_i;
      end else if (state == FLUSH) begin
        flush_cnt <= flush_cnt - FCW'(1);
      end
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (misp_accept) state_next = FLUSH;
      FLUSH:    if (flush_cnt == FCW'(1)) state_next = REDIRECT;
      REDIRECT: state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // FSM outputs; one queue slot stays reserved for the commit already in flight.
  always_comb begin
    commit_ready_o   = (state == RUN) && (count <= CW'(FREE_Q_DEPTH - 2));
    flush_o          = (state == FLUSH);
    redirect_valid_o = (state == REDIRECT);
    redirect_pc_o    = (state == REDIRECT) ? target : 64'd0;
  end

`ifdef RETIRE_PERF_EN
  logic [63:0] retired_cnt;
  logic [31:0] flush_cnt_total;

  // Performance counters: accepted commits and RUN->FLUSH transitions, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt     <= 64'd0;
      flush_cnt_total <= 32'd0;
    end else begin
      if (accept)
        retired_cnt <= retired_cnt + 64'd1;
      if ((state == RUN) && (state_next == FLUSH))
        flush_cnt_total <= flush_cnt_total + 32'd1;
    end
  end

  assign retired_count_o = retired_cnt;
  assign flush_count_o   = flush_cnt_total;
`else
  assign retired_count_o = 64'd0;
  assign flush_count_o   = 32'd0;
`endif

endmodule
